// File: rtl/fifo_axis_pkg.sv
// Shared types and default sizing for the FIFO-to-AXI4-Stream drain stage.
package fifo_axis_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } state_e;

  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefFrameLen = 256;
  localparam int unsigned DefLenW    = 16;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer between the FIFO read port and the stream output.
module fifo_skid_buf
  import fifo_axis_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop & (occ_q != 2'd0);
  assign do_push = push & ((occ_q != 2'd2) | do_pop);

  always_ff @(posedge clk) begin
    if (srst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ        = occ_q;
  assign head_valid = (occ_q != 2'd0);
  assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_axis_packer.sv
// Drains a 1-cycle-latency FIFO into fixed-length AXI4-Stream frames with tlast,
// stopping only on frame boundaries when enable drops.
module fifo_axis_packer
  import fifo_axis_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned FRAME_LEN = DefFrameLen,
  parameter int unsigned LEN_W     = DefLenW
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam logic [LEN_W-1:0] LastIdx = LEN_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic              inflight_q;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]       frame_cnt_q;
  logic              frame_done_q;

  logic [1:0]        occ;
  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic              last_beat;
  logic [1:0]        used;
  logic              slot_free;
  logic              rd_ok;
  logic              rd_en;
  logic              wrap_rd;

  fifo_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .srst       (srst),
    .push       (inflight_q),
    .push_data  (fifo_dout),
    .pop        (pop),
    .occ        (occ),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign pop       = head_valid & m_axis_tready;
  assign last_beat = (beat_cnt_q == LastIdx);

  // A beat leaving this cycle frees a slot, which keeps one beat per cycle going.
  assign used      = occ + {1'b0, inflight_q};
  assign slot_free = (used < 2'd2) | (pop & (used == 2'd2));

  // Never start the next frame's first read once enable has dropped.
  assign rd_ok   = (state_q != StFinish) & (enable | (rd_cnt_q != '0));
  assign rd_en   = ~srst & (state_q == StRun) & ~fifo_empty & slot_free & rd_ok;
  assign wrap_rd = rd_en & (rd_cnt_q == LastIdx);

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (rd_en) begin
      rd_cnt_d = wrap_rd ? '0 : rd_cnt_q + 1'b1;
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (~enable & (wrap_rd | (rd_cnt_q == '0))) state_d = StFinish;
      end
      StFinish: begin
        if ((occ == 2'd0) & ~inflight_q & (beat_cnt_q == '0)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= StIdle;
      inflight_q   <= 1'b0;
      rd_cnt_q     <= '0;
      beat_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= rd_en;
      rd_cnt_q     <= rd_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= pop & last_beat;
      if (pop & last_beat) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign fifo_rd_en    = rd_en;
  assign m_axis_tdata  = head_data;
  assign m_axis_tvalid = head_valid;
  assign m_axis_tlast  = head_valid & last_beat;
  assign busy          = (state_q != StIdle);
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_fifo_axis_packer.sv
// Randomized bench: FIFO model feeds the packer; a stream model checks order, framing and counters.
module tb_fifo_axis_packer;

  localparam int unsigned DW = 16;
  localparam int unsigned FL = 4;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_cnt;

  fifo_axis_packer #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .LEN_W     (16)
  ) dut (
    .clk           (clk),
    .srst          (srst),
    .enable        (enable),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream FIFO: words in, popped with one cycle of read latency.
  logic [DW-1:0] fq [$];

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
    else fifo_dout <= DW'($urandom);
  end

  always @(negedge clk) fifo_empty = (fq.size() == 0);

  // Stream model: output must be the FIFO word sequence, framed every FL beats.
  logic [DW-1:0] exp_q [$];
  int            beats = 0;
  logic [15:0]   frames = '0;
  int            done_pulses = 0;
  logic          done_exp = 1'b0;
  logic          stall = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    logic [DW-1:0] w;
    logic          last_exp;
    #2;
    if (srst) begin
      exp_q = fq;
      beats = 0;
      frames = '0;
      done_exp = 1'b0;
      stall = 1'b0;
    end else begin
      if (fifo_rd_en) check_eq("rd_while_empty", 32'(fifo_empty), 32'd0);
      if (stall) begin
        check_eq("hold_valid", 32'(m_axis_tvalid), 32'd1);
        check_eq("hold_data", 32'(m_axis_tdata), 32'(stall_data));
      end
      if (frame_done || done_exp) begin
        check_eq("frame_done", 32'(frame_done), 32'(done_exp));
        if (frame_done) done_pulses++;
        check_eq("frame_cnt_live", 32'(frame_cnt), 32'(frames));
      end
      done_exp = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check_eq("tdata", 32'(m_axis_tdata), 32'(w));
        end
        last_exp = ((beats % FL) == FL - 1);
        check_eq("tlast", 32'(m_axis_tlast), 32'(last_exp));
        beats++;
        if (last_exp) begin
          frames = frames + 16'd1;
          done_exp = 1'b1;
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
    end
  end

  // 0: ready high, 1: toggle, 2: random, 3: held low
  int rdy_mode = 0;

  task automatic tick();
    @(negedge clk);
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int c = 0;
    while (beats < n && c < budget) begin
      tick();
      c++;
    end
    check_eq(tag, 32'(beats), 32'(n));
  endtask

  initial begin
    int c;
    int base;
    int total;
    int pad;
    int sent;

    repeat (3) tick();
    srst = 1'b0;
    tick();
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Bytes 0x01..0x08 packed low byte first.
    enable = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) push_word({8'(2 * i + 2), 8'(2 * i + 1)});
    wait_beats("a_beats", 4, 200);
    repeat (3) tick();
    check_eq("a_frame_cnt", 32'(frame_cnt), 32'd1);
    check_eq("a_done_pulses", 32'(done_pulses), 32'd1);
    check_eq("a_busy", 32'(busy), 32'd1);

    // Preloaded, ready toggling every cycle.
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) push_word(DW'($urandom));
    wait_beats("b_beats", 20, 400);
    repeat (3) tick();
    check_eq("b_frame_cnt", 32'(frame_cnt), 32'd5);
    check_eq("b_done_pulses", 32'(done_pulses), 32'd5);

    // Bursty FIFO fill with random backpressure.
    rdy_mode = 2;
    sent = 0;
    c = 0;
    while (sent < 40 && c < 2000) begin
      tick();
      c++;
      if ($urandom_range(0, 2) != 0) begin
        push_word(DW'($urandom));
        sent++;
      end
    end
    wait_beats("c_beats", 60, 1000);
    repeat (3) tick();
    check_eq("c_frame_cnt", 32'(frame_cnt), 32'd15);

    // FIFO runs dry mid-frame, then refills.
    rdy_mode = 0;
    push_word(DW'($urandom));
    push_word(DW'($urandom));
    repeat (20) tick();
    check_eq("d_gap_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("d_gap_beats", 32'(beats), 32'd62);
    check_eq("d_gap_frames", 32'(frame_cnt), 32'd15);
    check_eq("d_gap_busy", 32'(busy), 32'd1);
    push_word(DW'($urandom));
    push_word(DW'($urandom));
    wait_beats("d_beats", 64, 200);
    repeat (3) tick();
    check_eq("d_frame_cnt", 32'(frame_cnt), 32'd16);

    // Drop enable after beat 2 of the second preloaded frame.
    base = beats;
    for (int i = 0; i < 16; i++) push_word(DW'($urandom));
    c = 0;
    while (beats < base + 6 && c < 300) begin
      tick();
      c++;
    end
    check_eq("e_reach", 32'(beats >= base + 6), 32'd1);
    enable = 1'b0;
    c = 0;
    while (busy && c < 300) begin
      tick();
      c++;
    end
    check_eq("e_busy", 32'(busy), 32'd0);
    repeat (10) tick();
    check_eq("e_beats", 32'(beats), 32'(base + 8));
    check_eq("e_frame_cnt", 32'(frame_cnt), 32'd18);
    check_eq("e_fifo_left", 32'(fq.size()), 32'd8);
    check_eq("e_tvalid", 32'(m_axis_tvalid), 32'd0);
    enable = 1'b1;
    wait_beats("e_resume", base + 16, 300);
    repeat (3) tick();
    check_eq("e_frame_cnt2", 32'(frame_cnt), 32'd20);

    // Reset while a read is in flight and a beat is presented.
    for (int i = 0; i < 8; i++) push_word(DW'($urandom));
    c = 0;
    while (!(fifo_rd_en && m_axis_tvalid) && c < 100) begin
      tick();
      c++;
    end
    check_eq("f_armed", 32'(fifo_rd_en && m_axis_tvalid), 32'd1);
    tick();
    srst = 1'b1;
    enable = 1'b0;
    rdy_mode = 3;
    m_axis_tready = 1'b0;
    tick();
    srst = 1'b0;
    check_eq("f_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("f_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("f_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("f_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("f_busy", 32'(busy), 32'd0);
    check_eq("f_frame_done", 32'(frame_done), 32'd0);
    check_eq("f_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (5) tick();
    check_eq("f_no_stale", 32'(m_axis_tvalid), 32'd0);
    total = fq.size();
    pad = (FL - (total % FL)) % FL;
    for (int i = 0; i < pad; i++) push_word(DW'($urandom));
    total += pad;
    enable = 1'b1;
    rdy_mode = 2;
    wait_beats("f_beats", total, 500);
    repeat (3) tick();
    check_eq("f_frame_cnt2", 32'(frame_cnt), 32'(total / FL));
    check_eq("f_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
